// File: rtl/mem_responder_pkg.sv
// Shared types and constants for mem_responder: data/mask widths, latency counter width,
// FSM state enum and the out-of-range address helper.
package mem_responder_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned MASK_W = 8;
   localparam int unsigned CNT_W  = 4;  // holds LATENCY-2 for LATENCY up to 15

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StResp
   } state_e;

   // True when any byte-address bit above the word-index field is set.
   function automatic logic addr_oob(input logic [XLEN-1:0] addr, input int unsigned aw);
      return (addr >> (aw + 3)) != '0;
   endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Word-wide storage for mem_responder: one synchronous byte-enabled write port and one
// registered read port. Contents are never reset.
module mem_responder_ram
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [MASK_W-1:0] wmask,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [XLEN-1:0]   rdata
);

   logic [XLEN-1:0] mem [DEPTH];
   logic [XLEN-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (wmask[i]) begin
               mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed request-to-response latency.
// Optional misaligned-address error check enabled by defining MEM_RESPONDER_MISALIGN_CHK_EN.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [MASK_W-1:0] req_wmask,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              write_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [MASK_W-1:0] wmask_q;

   logic              accept;
   logic              enter_resp;
   logic              cur_write;
   logic [XLEN-1:0]   cur_addr;
   logic [XLEN-1:0]   cur_wdata;
   logic [MASK_W-1:0] cur_wmask;
   logic              cur_err;
   logic              misalign;
   logic [XLEN-1:0]   ram_rdata;

   assign accept = req_valid && req_ready;

   // With LATENCY==1 RESP is entered on the accept edge, before the request is latched.
   assign cur_write = (state_q == StIdle) ? req_write : write_q;
   assign cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
   assign cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
   assign cur_wmask = (state_q == StIdle) ? req_wmask : wmask_q;

`ifdef MEM_RESPONDER_MISALIGN_CHK_EN
   assign misalign = cur_addr[2:0] != 3'b000;
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^cur_addr[2:0];
   assign misalign = 1'b0;
`endif

   assign cur_err = addr_oob(cur_addr, AW) || misalign;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d    = StResp;
                  enter_resp = 1'b1;
               end else begin
                  state_d = StBusy;
                  cnt_d   = CNT_W'(LATENCY - 2);
               end
            end
         end
         StBusy: begin
            if (cnt_q == '0) begin
               state_d    = StResp;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
         end
      end
   end

   // Gating with rst discards a store whose commit edge coincides with reset.
   mem_responder_ram #(
      .DEPTH(DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (enter_resp && rst && cur_write && !cur_err),
      .waddr(cur_addr[AW+2:3]),
      .wdata(cur_wdata),
      .wmask(cur_wmask),
      .re   (enter_resp && rst && !cur_write && !cur_err),
      .raddr(cur_addr[AW+2:3]),
      .rdata(ram_rdata)
   );

   assign req_ready  = rst && (state_q == StIdle);
   assign resp_valid = rst && (state_q == StResp);
   assign resp_err   = resp_valid && cur_err;
   assign resp_rdata = (resp_valid && !write_q && !cur_err) ? ram_rdata : '0;

endmodule
